// File: rtl/countdown_timer_pkg.sv
// countdown_timer_pkg: shared state encoding for the countdown timer
package countdown_timer_pkg;
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;
  typedef enum logic {IDLE = ST_IDLE, RUN = ST_RUN} state_t;
endpackage

// File: rtl/countdown_timer_if.sv
// countdown_timer_if: load handshake, control and status bundle of the countdown timer
//   master (controller): drives clear, en, load_valid, load_value; observes load_ready, cnt, busy, done
//   slave  (timer)     : the reverse
interface countdown_timer_if #(parameter int width = 8);
  logic clear;
  logic en;
  logic load_valid;
  logic [width-1:0] load_value;
  logic load_ready;
  logic [width-1:0] cnt;
  logic busy;
  logic done;
  modport master(output clear, en, load_valid, load_value, input load_ready, cnt, busy, done);
  modport slave(input clear, en, load_valid, load_value, output load_ready, cnt, busy, done);
endinterface

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with one-cycle registered done pulse on expiry
//   i_clk   : rising-edge clock
//   i_rst_n : asynchronous active-low reset
//   bus     : countdown_timer_if.slave (clear, en, load handshake, cnt, busy, done)
//   Optional macro COUNTDOWN_TIMER_AUTO_RELOAD_EN: reload the stored period at expiry and
//   accept period updates while running.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int width = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  countdown_timer_if.slave   bus
);
  state_t           r_state;
  logic [width-1:0] r_cnt;
  logic             r_done;
  logic             w_load;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
  logic [width-1:0] r_period;
  assign bus.load_ready = 1'b1;
`else
  assign bus.load_ready = (r_state == IDLE);
`endif
  assign w_load   = bus.load_valid && bus.load_ready;
  assign bus.cnt  = r_cnt;
  assign bus.busy = (r_state == RUN);
  assign bus.done = r_done;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_done   <= 1'b0;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
      r_period <= '0;
`endif
    end else if (bus.clear) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else if (r_state == IDLE) begin
      // a zero load expires immediately without ever entering RUN
      r_done <= w_load && (bus.load_value == '0);
      if (w_load) begin
        r_cnt   <= bus.load_value;
        r_state <= (bus.load_value == '0) ? IDLE : RUN;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
        r_period <= bus.load_value;
`endif
      end
    end else begin
      // RUN never holds a zero count, so expiry is detected at 1
      r_done <= bus.en && (r_cnt == 1);
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
      if (w_load) r_period <= bus.load_value;
`endif
      if (bus.en) begin
        if (r_cnt != 1) r_cnt <= r_cnt - 1'b1;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
        else begin
          // the old period applies here; a same-cycle load only affects the next expiry
          r_cnt   <= r_period;
          r_state <= (r_period == '0) ? IDLE : RUN;
        end
`else
        else begin
          r_cnt   <= '0;
          r_state <= IDLE;
        end
`endif
      end
    end
  end
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: randomized and directed checks of countdown_timer against a behavioural model
module tb_countdown_timer;
  localparam int W = 8;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
  localparam bit reload = 1'b1;
`else
  localparam bit reload = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  int m_cnt, m_period;
  bit m_run, m_done;
  countdown_timer_if #(.width(W)) bus ();
  countdown_timer #(.width(W)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_cnt = 0;
    m_period = 0;
    m_run = 0;
    m_done = 0;
  endtask
  task automatic model_step(input bit c, input bit e, input bit lv, input int v);
    int old_period;
    old_period = m_period;
    if (c) begin
      m_run = 0;
      m_cnt = 0;
      m_done = 0;
    end else if (!m_run) begin
      m_done = lv && v == 0;
      if (lv) begin
        m_cnt = v;
        m_period = v;
        m_run = v != 0;
      end
    end else begin
      m_done = 0;
      if (lv && reload) m_period = v;
      if (e) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          m_done = 1;
          if (reload && old_period != 0) m_cnt = old_period;
          else m_run = 0;
        end
      end
    end
  endtask
  task automatic tick(input bit c, input bit e, input bit lv, input int v);
    chk("cnt", int'(bus.cnt), m_cnt);
    chk("busy", int'(bus.busy), int'(m_run));
    chk("done", int'(bus.done), int'(m_done));
    chk("load_ready", int'(bus.load_ready), int'(!m_run || reload));
    bus.clear = c;
    bus.en = e;
    bus.load_valid = lv;
    bus.load_value = W'(v);
    model_step(c, e, lv, v);
    @(negedge clk);
  endtask
  initial begin
    bus.clear = 1'b0;
    bus.en = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_value = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_cnt", int'(bus.cnt), 0);
    chk("rst_done", int'(bus.done), 0);
    rst_n = 1'b1;
    tick(0, 0, 0, 0);
    // load 3 with en high: 3,2,1,0 and done with 0
    tick(0, 1, 1, 3);
    chk("ld3_cnt", int'(bus.cnt), 3);
    repeat (4) tick(0, 1, 0, 0);
    // load 4 with toggling enable
    tick(0, 0, 1, 4);
    for (int i = 0; i < 10; i++) tick(0, i[0] == 1'b0, 0, 0);
    // zero load gives a pulse without busy; back-to-back zero loads pulse each time
    tick(0, 1, 1, 0);
    chk("z_done", int'(bus.done), 1);
    chk("z_busy", int'(bus.busy), 0);
    tick(0, 1, 1, 0);
    tick(0, 1, 0, 0);
    // load 1 expires after one enabled edge
    tick(0, 1, 1, 1);
    tick(0, 1, 0, 0);
    tick(0, 0, 0, 0);
    // clear on the expiry edge suppresses done
    tick(0, 1, 1, 1);
    tick(1, 1, 0, 0);
    chk("clr_done", int'(bus.done), 0);
    chk("clr_busy", int'(bus.busy), 0);
    // clear together with a load ignores the load
    tick(1, 1, 1, 7);
    chk("clr_ld_cnt", int'(bus.cnt), 0);
    tick(0, 0, 0, 0);
    // auto-reload pattern: load 2, then 3 mid-run
    tick(0, 1, 1, 2);
    repeat (3) tick(0, 1, 0, 0);
    tick(0, 1, 1, 3);
    repeat (8) tick(0, 1, 0, 0);
    tick(1, 0, 0, 0);
    // asynchronous reset mid-run with cnt = 5
    tick(0, 0, 1, 5);
    chk("pre_rst_cnt", int'(bus.cnt), 5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cnt", int'(bus.cnt), 0);
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_done", int'(bus.done), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    chk("arst_ready", int'(bus.load_ready), 1);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int v;
      v = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 6));
      tick($urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, v);
    end
    tick(0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
